l1_refill_arbiter: RTL
======================

Name: l1_refill_arbiter

Overview:
Shares one backing block memory between the instruction L1 and data L1 miss paths. Accepts 128-bit block read/write requests from both caches and arbitrates them round-robin. Drives the memory through a request/ready handshake and returns the delivered block and a one-cycle delivered pulse to the winning cache. Sits between both L1 instances and the parameterized main memory, one level below the CPU-facing memory wrappers.

Parameters:
BLOCK_W, 128, block width in bits (4 words).
ADDR_W, 28, block address width (byte address bits 31:4).
TIMEOUT, 64, cycles to wait for mem_ready before aborting; must be >= 2.

Ports:
CLK  in  1  clock, all state on rising edge.
RST  in  1  reset, asynchronous, active-high.
i_req  in  1  IL1 miss request; level, held until i_delivered.
i_addr  in  ADDR_W  IL1 block address; stable while i_req is high.
i_delivered  out  1  one-cycle pulse: i_block valid.
i_block  out  BLOCK_W  block returned to IL1.
d_req  in  1  DL1 request; level, held until d_delivered.
d_we  in  1  1 = write-back of d_wblock, 0 = refill read.
d_addr  in  ADDR_W  DL1 block address.
d_wblock  in  BLOCK_W  DL1 write-back data.
d_delivered  out  1  one-cycle pulse: read data valid or write committed.
d_block  out  BLOCK_W  block returned to DL1.
mem_req  out  1  memory request; held until mem_ready.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory block address.
mem_wdata  out  BLOCK_W  memory write data.
mem_rdata  in  BLOCK_W  memory read data, valid with mem_ready.
mem_ready  in  1  one-cycle pulse: access complete.
err  out  1  one-cycle pulse on timeout abort.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; last_grant = D, so IL1 wins the first tie; timeout counter = 0. Reset mid-transaction aborts with no delivered pulse. Requesters must re-request after reset.
- States are IDLE, MEM, DONE.
- IDLE:
  - If only one requester is high, grant it.
  - If both are high, grant the requester other than last_grant.
  - On grant, latch the owner, addr, we and wdata into registers. Next cycle: state = MEM, mem_req = 1 with the latched fields. For an I grant, mem_we is always 0.
- MEM:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant from the registers.
  - On mem_ready: capture mem_rdata into the owner's block output register and pulse the owner's delivered signal in the next cycle, i.e. in DONE. Also drop mem_req, set last_grant = owner, and go to DONE.
  - For a d_we write, d_block is left unchanged.
- DONE:
  - Exactly one cycle, with the delivered pulse high. It gives the requester a cycle to drop req.
  - Return to IDLE without arbitrating in this cycle.
  - A req still high in IDLE is treated as a new request.
- Latency: req high in IDLE -> mem_req high on cycle +1. mem_ready on cycle n -> delivered pulse on cycle n+1. Best case (memory ready the cycle after mem_req) is delivered at +3 from req.
- Block outputs hold their last value between deliveries.
- Timeout:
  - The counter increments each MEM cycle without mem_ready.
  - When it reaches TIMEOUT-1 without mem_ready: pulse err, drop mem_req, give no delivered pulse, set last_grant = owner, and go to IDLE.
  - The counter clears on leaving MEM.
- mem_ready outside MEM is ignored.
- A req that rises while the other requester is in service waits. Round-robin bounds its wait to one transaction.
- A req deasserted before grant is simply not served. A req deasserted after grant does not cancel the transaction.

Decomposition:
- Shared package l1_mem_pkg:
  - typedef owner_e {OWN_I, OWN_D};
  - typedef state_e {IDLE, MEM, DONE};
  - BLOCK_W and ADDR_W defaults;
  - block_t = logic [BLOCK_W-1:0].
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter. It is combinational grant plus a last_grant register updated by an enable.

Test Plan:
- Single I read: i_req = 1 with i_addr = 0x0000010; memory returns 0xDEADBEEF_..._0001 after 3 cycles -> mem_req high 3 cycles with mem_we = 0 and mem_addr = 0x0000010; i_delivered pulses 1 cycle with i_block equal to the returned data; d_delivered stays 0.
- Simultaneous requests after reset: i_req and d_req raised on the same cycle -> I served first, then D; second mem_req asserts 2 cycles after i_delivered. Repeat with both held -> grants alternate I, D, I, D.
- D write-back: d_we = 1, d_addr = 0x0ABCDEF, d_wblock = {4{32'h12345678}} -> mem_we = 1 with matching addr and wdata; d_delivered pulses; d_block unchanged.
- Timeout: TIMEOUT = 8, mem_ready never asserted -> err pulses in the 8th MEM cycle, mem_req drops, no delivered pulse, busy = 0 next cycle.
- Reset mid-MEM: RST asserted asynchronously 2 cycles into MEM -> mem_req, busy and both delivered signals go 0 immediately; after release, i_req is granted first.
- Stray mem_ready while in IDLE -> no delivered pulse, block outputs unchanged.

Source files
------------

// File: rtl/l1_mem_pkg.sv
// Shared types, default widths and the round-robin pick rule for the L1 refill path.
package l1_mem_pkg;

  localparam int BLOCK_W = 128;
  localparam int ADDR_W  = 28;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, DONE = 2'd2} state_e;
  typedef logic [BLOCK_W-1:0] block_t;

  // On a tie the requester that did not win last time goes first.
  function automatic owner_e rr_pick(input logic i_req, input logic d_req, input owner_e last_grant);
    owner_e pick;
    if (i_req && d_req) begin
      pick = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end else if (d_req) begin
      pick = OWN_D;
    end else begin
      pick = OWN_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/l1_refill_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus an enabled last_grant register.
module rr_arb2
  import l1_mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   upd_en,
  input  owner_e upd_owner,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  owner_e last_grant_r;

  // Last completed owner; reset favours IL1 on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= OWN_D;
    end else if (upd_en) begin
      last_grant_r <= upd_owner;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign gnt_valid = i_req | d_req;
  assign gnt_owner = rr_pick(i_req, d_req, last_grant_r);

endmodule

// File: rtl/l1_refill_arbiter.sv
// Arbitrates IL1 and DL1 block requests onto one main-memory port with a timeout abort.
module l1_refill_arbiter #(
  parameter int BLOCK_W = l1_mem_pkg::BLOCK_W,
  parameter int ADDR_W  = l1_mem_pkg::ADDR_W,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic               i_delivered,
  output logic [BLOCK_W-1:0] i_block,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wblock,
  output logic               d_delivered,
  output logic [BLOCK_W-1:0] d_block,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               err,
  output logic               busy
);
  import l1_mem_pkg::*;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e              state_r, state_n;
  owner_e              owner_r, owner_n;
  logic [ADDR_W-1:0]   addr_r, addr_n;
  logic                we_r, we_n;
  logic [BLOCK_W-1:0]  wdata_r, wdata_n;
  logic [BLOCK_W-1:0]  i_block_r, i_block_n, d_block_r, d_block_n;
  logic [CNT_W-1:0]    cnt_r, cnt_n;
  logic                mem_req_r, mem_req_n, err_r, err_n, busy_r, busy_n;
  logic                i_del_r, i_del_n, d_del_r, d_del_n;
  logic                gnt_valid_s, arb_upd_s;
  owner_e              gnt_owner_s;

  rr_arb2 u_arb (
    .clk       (CLK),
    .rst       (RST),
    .i_req     (i_req),
    .d_req     (d_req),
    .upd_en    (arb_upd_s),
    .upd_owner (owner_r),
    .gnt_valid (gnt_valid_s),
    .gnt_owner (gnt_owner_s)
  );

  // Next-state and next-register values; MEM with mem_req low is the one-cycle abort tail.
  always_comb begin
    state_n   = state_r;
    owner_n   = owner_r;
    addr_n    = addr_r;
    we_n      = we_r;
    wdata_n   = wdata_r;
    i_block_n = i_block_r;
    d_block_n = d_block_r;
    cnt_n     = cnt_r;
    mem_req_n = mem_req_r;
    err_n     = 1'b0;
    i_del_n   = 1'b0;
    d_del_n   = 1'b0;
    arb_upd_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_n = {CNT_W{1'b0}};
        if (gnt_valid_s) begin
          state_n   = MEM;
          owner_n   = gnt_owner_s;
          mem_req_n = 1'b1;
          if (gnt_owner_s == OWN_I) begin
            addr_n  = i_addr;
            we_n    = 1'b0;
            wdata_n = {BLOCK_W{1'b0}};
          end else begin
            addr_n  = d_addr;
            we_n    = d_we;
            wdata_n = d_wblock;
          end
        end else begin
          state_n = IDLE;
        end
      end
      MEM: begin
        if (!mem_req_r) begin
          state_n = IDLE;
          cnt_n   = {CNT_W{1'b0}};
        end else if (mem_ready) begin
          state_n   = DONE;
          mem_req_n = 1'b0;
          cnt_n     = {CNT_W{1'b0}};
          arb_upd_s = 1'b1;
          if (owner_r == OWN_I) begin
            i_del_n   = 1'b1;
            i_block_n = mem_rdata;
          end else begin
            d_del_n = 1'b1;
            if (!we_r) begin
              d_block_n = mem_rdata;
            end else begin
              d_block_n = d_block_r;
            end
          end
        end else if (cnt_r == CNT_W'(TIMEOUT - 2)) begin
          err_n     = 1'b1;
          mem_req_n = 1'b0;
          cnt_n     = cnt_r + CNT_W'(1'b1);
          arb_upd_s = 1'b1;
        end else begin
          cnt_n = cnt_r + CNT_W'(1'b1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // All state and every output lives in these registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      owner_r   <= OWN_I;
      addr_r    <= {ADDR_W{1'b0}};
      we_r      <= 1'b0;
      wdata_r   <= {BLOCK_W{1'b0}};
      i_block_r <= {BLOCK_W{1'b0}};
      d_block_r <= {BLOCK_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      mem_req_r <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      i_del_r   <= 1'b0;
      d_del_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      owner_r   <= owner_n;
      addr_r    <= addr_n;
      we_r      <= we_n;
      wdata_r   <= wdata_n;
      i_block_r <= i_block_n;
      d_block_r <= d_block_n;
      cnt_r     <= cnt_n;
      mem_req_r <= mem_req_n;
      err_r     <= err_n;
      busy_r    <= busy_n;
      i_del_r   <= i_del_n;
      d_del_r   <= d_del_n;
    end
  end

  assign i_delivered = i_del_r;
  assign d_delivered = d_del_r;
  assign i_block     = i_block_r;
  assign d_block     = d_block_r;
  assign mem_req     = mem_req_r;
  assign mem_we      = we_r;
  assign mem_addr    = addr_r;
  assign mem_wdata   = wdata_r;
  assign err         = err_r;
  assign busy        = busy_r;

endmodule
